// File: rtl/regwrite_arbiter.sv
// Two-requester round-robin arbiter in front of a single writeback pipeline register.
// The register is a 1-entry buffer with an owner tag and a saturating accept counter.
module regwrite_arbiter #(
  parameter int N  = 64,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [N-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [N-1:0]  req1_data,
  output logic          req1_ready,
  output logic [N-1:0]  q,
  output logic          q_owner,
  output logic          q_valid,
  input  logic          q_ready,
  output logic [CW-1:0] load_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] count_q, count_d;

  logic          load_en_s;
  logic          grant_vld_s;
  logic          grant_idx_s;
  logic          accept_s;
  logic          acc_idx_s;
  logic [N-1:0]  acc_data_s;

  // A full register being drained this cycle can take a new load at the same edge.
  assign load_en_s = (state_q == ST_EMPTY) | q_ready;

  // Round-robin grant: a lone requester always wins, a conflict goes to prio_q.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: begin
        grant_vld_s = 1'b1;
        grant_idx_s = 1'b0;
      end
      2'b10: begin
        grant_vld_s = 1'b1;
        grant_idx_s = 1'b1;
      end
      2'b11: begin
        grant_vld_s = 1'b1;
        grant_idx_s = prio_q;
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_idx_s = 1'b0;
      end
    endcase
  end

  assign req0_ready = load_en_s & grant_vld_s & (grant_idx_s == 1'b0) & ~reset;
  assign req1_ready = load_en_s & grant_vld_s & (grant_idx_s == 1'b1) & ~reset;

  assign accept_s   = req0_ready | req1_ready;
  assign acc_idx_s  = req1_ready;
  assign acc_data_s = req1_ready ? req1_data : req0_data;

  // Next-state for the buffer, owner tag, priority and accept counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    count_d = count_q;
    if (accept_s) begin
      state_d = ST_FULL;
      data_d  = acc_data_s;
      owner_d = acc_idx_s;
      prio_d  = ~acc_idx_s;
      if (count_q != {CW{1'b1}}) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
    end else if ((state_q == ST_FULL) && q_ready) begin
      // Drain without reload keeps the stale payload and owner visible.
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset discards any pending payload and re-arms priority to req0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= {N{1'b0}};
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      count_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      count_q <= count_d;
    end
  end

  assign q          = data_q;
  assign q_owner    = owner_q;
  assign q_valid    = (state_q == ST_FULL);
  assign load_count = count_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: directed stimulus pushes expected q/owner pairs,
// a negedge monitor pops them whenever the consumer handshake completes.
module tb_regwrite_arbiter;

  localparam int N  = 64;
  localparam int CW = 4;

  typedef struct packed {
    logic [N-1:0] d;
    logic         o;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          req0_valid;
  logic [N-1:0]  req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [N-1:0]  req1_data;
  logic          req1_ready;
  logic [N-1:0]  q;
  logic          q_owner;
  logic          q_valid;
  logic          q_ready;
  logic [CW-1:0] load_count;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  regwrite_arbiter #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .q          (q),
    .q_owner    (q_owner),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Monitor: protocol sanity every cycle, scoreboard compare on each consumer handshake.
  always @(negedge clk) begin
    if (!reset) begin
      chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
      chk("ready_wo_valid", {63'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 64'd0);
      if (q_valid && q_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_q: got 0x%0h owner %0d expected no output", q, q_owner);
        end else begin
          mon_e = sb.pop_front();
          chk("q_data", q, mon_e.d);
          chk("q_owner", {63'd0, q_owner}, {63'd0, mon_e.o});
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 64'd5;
    req1_valid = 1'b1;
    req1_data  = 64'd9;
    q_ready    = 1'b1;

    // Reset hold with both requesters pending.
    #52;
    chk("rst_q", q, 64'd0);
    chk("rst_q_valid", {63'd0, q_valid}, 64'd0);
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
    chk("rst_count", {60'd0, load_count}, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready0", {63'd0, req0_ready}, 64'd1);
    chk("post_rst_ready1", {63'd0, req1_ready}, 64'd0);
    push(64'd5, 1'b0);
    step();
    idle(3);
    pulse_reset();

    // Single requester at full throughput.
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      req0_data  = 64'(i);
      push(64'(i), 1'b0);
      step();
    end
    chk("single_count", {60'd0, load_count}, 64'd10);
    idle(3);
    pulse_reset();

    // Contention alternates starting with req0.
    req0_valid = 1'b1;
    req0_data  = 64'hA;
    req1_valid = 1'b1;
    req1_data  = 64'hB;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push(64'hA, 1'b0);
      else            push(64'hB, 1'b1);
      step();
    end
    idle(3);
    pulse_reset();

    // Backpressure, then same-cycle reload when the consumer resumes.
    req0_valid = 1'b1;
    req0_data  = 64'h3;
    push(64'h3, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 64'h77;
    q_ready    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready1", {63'd0, req1_ready}, 64'd0);
      chk("bp_q", q, 64'h3);
      step();
    end
    push(64'h77, 1'b1);
    q_ready = 1'b1;
    #1;
    chk("resume_ready1", {63'd0, req1_ready}, 64'd1);
    step();
    req1_valid = 1'b0;
    chk("reload_q", q, 64'h77);
    step();

    // Drain keeps the value; async reset while full clears immediately.
    chk("drain_q_valid", {63'd0, q_valid}, 64'd0);
    chk("drain_q", q, 64'h77);
    chk("drain_owner", {63'd0, q_owner}, 64'd1);
    req0_valid = 1'b1;
    req0_data  = 64'h55;
    step();
    req0_valid = 1'b0;
    q_ready    = 1'b0;
    #2;
    chk("full_q_valid", {63'd0, q_valid}, 64'd1);
    chk("full_q", q, 64'h55);
    reset = 1'b1;
    #1;
    chk("async_rst_q", q, 64'd0);
    chk("async_rst_q_valid", {63'd0, q_valid}, 64'd0);
    chk("async_rst_count", {60'd0, load_count}, 64'd0);
    reset = 1'b0;
    q_ready = 1'b1;
    step();

    // Accept counter saturates at 2^CW-1.
    for (int i = 0; i < 20; i++) begin
      req0_valid = 1'b1;
      req0_data  = 64'(i + 100);
      push(64'(i + 100), 1'b0);
      step();
      chk("sat_count", {60'd0, load_count}, (i + 1 > 15) ? 64'd15 : 64'(i + 1));
    end
    idle(3);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
